// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions used by both the receive decoder and the transmitter:
// data-type codes, decoder state encoding, header ECC and CRC seed.
package csi2_pkg;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_YUV422_8 = 6'h1E;

  // Data types below this value are short packets (no payload, no CRC).
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Decoder states
  // state      | meaning
  // ST_IDLE    | waiting for the DI byte of a new burst
  // ST_HDR     | collecting WC_LSB, WC_MSB and ECC
  // ST_PAYLOAD | forwarding WC payload bytes to the pixel port
  // ST_SKIP    | discarding payload of an unwanted long packet
  // ST_CRC     | taking the 2 checksum bytes (checked or discarded)
  // ST_DONE    | packet finished, ignoring trailer until burst ends
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_SKIP    = 3'd3;
  localparam logic [2:0] ST_CRC     = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // 6-bit Hamming parity over {WC_MSB, WC_LSB, DI}.
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Byte-wide CCITT CRC16 (reflected, x^16+x^12+x^5+1) with synchronous clear.
module csi2_crc16 (
  input  logic        byte_clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  import csi2_pkg::*;

  logic [15:0] r_crc;
  logic [15:0] w_next;

  // Fold one byte into the running CRC, least significant bit first.
  always_comb begin
    w_next = r_crc;
    for (int i = 0; i < 8; i++) begin
      if (w_next[0] ^ data[i]) w_next = (w_next >> 1) ^ 16'h8408;
      else                     w_next = w_next >> 1;
    end
  end

  // CRC register: clear reseeds at the start of each payload.
  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n)   r_crc <= CRC_INIT;
    else if (clear) r_crc <= CRC_INIT;
    else if (en)    r_crc <= w_next;
  end

  assign crc = r_crc;

endmodule

// File: rtl/csi2_rx_packet_decoder.sv
// Single-lane CSI-2 packet decoder: parses one packet per HS burst, rebuilds
// FV/LV/PIXDATA and flags header ECC, payload CRC, oversize and truncation errors.
module csi2_rx_packet_decoder #(
  parameter logic [1:0]  VC     = 2'd0,
  parameter logic [5:0]  DT     = 6'h1E,
  parameter logic [15:0] WC_MAX = 16'h0F00,
  parameter bit          crc16  = 1'b1
) (
  input  logic       byte_clk,
  input  logic       reset_n,
  input  logic       hs_active,
  input  logic       hs_valid,
  input  logic [7:0] hs_data,
  output logic       FV,
  output logic       LV,
  output logic [7:0] PIXDATA,
  output logic       ecc_err,
  output logic       crc_err,
  output logic       wc_err,
  output logic       trunc_err
);
  import csi2_pkg::*;

  logic [2:0]  r_state;
  logic [23:0] r_hdr;
  logic [15:0] r_cnt;
  logic [7:0]  r_crc_lsb;
  logic        r_chk;
  logic        r_fv, r_lv, r_ecc_err, r_crc_err, r_wc_err, r_trunc_err;
  logic [7:0]  r_pix;

  logic [1:0]  w_vc;
  logic [5:0]  w_dt;
  logic [15:0] w_wc;
  logic        w_last;
  logic        w_ecc_ok;
  logic        w_take;
  logic        w_crc_clear;
  logic        w_crc_en;
  logic [15:0] w_crc;

  assign w_vc     = r_hdr[7:6];
  assign w_dt     = r_hdr[5:0];
  assign w_wc     = r_hdr[23:8];
  assign w_last   = (r_cnt == 16'd1);
  assign w_take   = hs_active && hs_valid;
  assign w_ecc_ok = (hs_data[7:6] == 2'b00) && (hs_data[5:0] == csi2_ecc(r_hdr));

  // Reseed on the ECC byte that accepts a forwarded long packet (also covers WC=0).
  assign w_crc_clear = (r_state == ST_HDR) && w_take && w_last && w_ecc_ok &&
                       (w_vc == VC) && (w_dt == DT) && (w_wc <= WC_MAX);
  assign w_crc_en    = (r_state == ST_PAYLOAD) && w_take;

  csi2_crc16 u_crc (
    .byte_clk (byte_clk),
    .reset_n  (reset_n),
    .clear    (w_crc_clear),
    .en       (w_crc_en),
    .data     (hs_data),
    .crc      (w_crc)
  );

  // Packet FSM, byte down-counter, header capture and registered outputs.
  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_hdr       <= 24'd0;
      r_cnt       <= 16'd0;
      r_crc_lsb   <= 8'd0;
      r_chk       <= 1'b0;
      r_fv        <= 1'b0;
      r_lv        <= 1'b0;
      r_pix       <= 8'd0;
      r_ecc_err   <= 1'b0;
      r_crc_err   <= 1'b0;
      r_wc_err    <= 1'b0;
      r_trunc_err <= 1'b0;
    end else begin
      r_lv        <= 1'b0;
      r_ecc_err   <= 1'b0;
      r_crc_err   <= 1'b0;
      r_wc_err    <= 1'b0;
      r_trunc_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_hdr   <= {hs_data, r_hdr[23:8]};
            r_cnt   <= 16'd3;
            r_state <= ST_HDR;
          end
        end
        ST_DONE: begin
          if (!hs_active) r_state <= ST_IDLE;
        end
        default: begin
          if (!hs_active) begin
            r_trunc_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (hs_valid) begin
            r_cnt <= r_cnt - 16'd1;
            case (r_state)
              ST_HDR: begin
                if (!w_last) begin
                  r_hdr <= {hs_data, r_hdr[23:8]};
                end else begin
                  r_state <= ST_DONE;
                  if (!w_ecc_ok) begin
                    r_ecc_err <= 1'b1;
                  end else if (w_vc == VC) begin
                    if (w_dt < DT_LONG_MIN) begin
                      if (w_dt == DT_FS)      r_fv <= 1'b1;
                      else if (w_dt == DT_FE) r_fv <= 1'b0;
                    end else if ((w_dt != DT) || (w_wc > WC_MAX)) begin
                      r_wc_err <= (w_wc > WC_MAX);
                      r_chk    <= 1'b0;
                      if (w_wc == 16'd0) begin
                        r_state <= ST_CRC;
                        r_cnt   <= 16'd2;
                      end else begin
                        r_state <= ST_SKIP;
                        r_cnt   <= w_wc;
                      end
                    end else if (w_wc == 16'd0) begin
                      r_state <= ST_CRC;
                      r_cnt   <= 16'd2;
                      r_chk   <= crc16;
                    end else begin
                      r_state <= ST_PAYLOAD;
                      r_cnt   <= w_wc;
                    end
                  end
                end
              end
              ST_PAYLOAD: begin
                r_lv  <= 1'b1;
                r_pix <= hs_data;
                if (w_last) begin
                  r_state <= ST_CRC;
                  r_cnt   <= 16'd2;
                  r_chk   <= crc16;
                end
              end
              // Skipped payload reuses the CRC state with checking disabled.
              ST_SKIP: begin
                if (w_last) begin
                  r_state <= ST_CRC;
                  r_cnt   <= 16'd2;
                end
              end
              ST_CRC: begin
                if (!w_last) begin
                  r_crc_lsb <= hs_data;
                end else begin
                  r_crc_err <= r_chk && ({hs_data, r_crc_lsb} != w_crc);
                  r_state   <= ST_DONE;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign FV        = r_fv;
  assign LV        = r_lv;
  assign PIXDATA   = r_pix;
  assign ecc_err   = r_ecc_err;
  assign crc_err   = r_crc_err;
  assign wc_err    = r_wc_err;
  assign trunc_err = r_trunc_err;

endmodule
